mdu_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core; sits beside the EX-stage ALU.

---
 rtl/mdu_unit_pkg.sv | 24 ++
 rtl/mdu_unit_countdown.sv | 30 +++
 rtl/mdu_unit.sv | 121 ++++++++++++
 tb/tb_mdu_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared MDU opcode encoding and sizing helpers for the multiply/divide unit,
// its decoder/control and the hazard unit.
package mdu_unit_pkg;

    localparam int MDU_OPW = 4;

    typedef enum logic [MDU_OPW-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    // Counter must hold the larger of the two latencies.
    function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
        return $clog2(((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1);
    endfunction

endpackage

// File: rtl/mdu_unit_countdown.sv
// Loadable down-counter for the MDU busy window; flags the final cycle of the
// count so the result can commit on the 1->0 edge.
module mdu_unit_countdown #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic          zero;

    assign zero   = (cnt_q == '0);
    assign last_o = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && !zero) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. Results are computed
// at issue, held in pending registers, and committed after the configured latency.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MDU_OPW-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   rdata
);

    localparam int CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);

    mdu_op_e op_e;
    logic    is_mult, is_div, issue, cnt_last;

    logic               busy_q;
    logic [WIDTH-1:0]   hi_q, lo_q, pend_hi_q, pend_lo_q;
    logic [WIDTH-1:0]   pend_hi_d, pend_lo_d;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]   b_safe, q_s, r_s, q_u, r_u;
    logic               div_zero, div_ovf;
    logic [CW-1:0]      load_val;

    assign op_e    = mdu_op_e'(op);
    assign is_mult = (op_e == MDU_MULT) || (op_e == MDU_MULTU);
    assign is_div  = (op_e == MDU_DIV)  || (op_e == MDU_DIVU);
    assign issue   = start && !busy_q;

    // Sign- or zero-extend to full product width so no bits are lost before the split.
    assign a_ext = (op_e == MDU_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign b_ext = (op_e == MDU_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign prod  = a_ext * b_ext;

    // Divide-by-zero and most-negative/-1 are muxed out so the divider never sees them.
    assign div_zero = (b == '0);
    assign div_ovf  = (op_e == MDU_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign b_safe   = (div_zero || div_ovf) ? WIDTH'(1) : b;
    assign q_s      = $signed(a) / $signed(b_safe);
    assign r_s      = $signed(a) % $signed(b_safe);
    assign q_u      = a / b_safe;
    assign r_u      = a % b_safe;

    always_comb begin
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (is_mult) begin
            pend_hi_d = prod[2*WIDTH-1:WIDTH];
            pend_lo_d = prod[WIDTH-1:0];
        end else if (is_div) begin
            if (div_zero) begin
                pend_hi_d = a;
                pend_lo_d = '1;
            end else if (div_ovf) begin
                pend_hi_d = '0;
                pend_lo_d = a;
            end else if (op_e == MDU_DIV) begin
                pend_hi_d = r_s;
                pend_lo_d = q_s;
            end else begin
                pend_hi_d = r_u;
                pend_lo_d = q_u;
            end
        end
    end

    assign load_val = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

    mdu_unit_countdown #(.CW(CW)) u_countdown (
        .clk        (clk),
        .reset      (reset),
        .load_i     (issue && (is_mult || is_div)),
        .load_val_i (load_val),
        .dec_i      (busy_q),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else if (busy_q) begin
            if (cnt_last) begin
                hi_q   <= pend_hi_q;
                lo_q   <= pend_lo_q;
                busy_q <= 1'b0;
            end
        end else if (start) begin
            unique case (op_e)
                MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                    pend_hi_q <= pend_hi_d;
                    pend_lo_q <= pend_lo_d;
                    busy_q    <= 1'b1;
                end
                MDU_MTHI: hi_q <= a;
                MDU_MTLO: lo_q <= a;
                default: ;
            endcase
        end
    end

    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = (op_e == MDU_MFHI) ? hi_q :
                   (op_e == MDU_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit at the default 32-bit configuration plus a
// 16-bit short-latency instance checked against a longint reference model.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo, rdata;
    logic        busy;

    logic        start16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, hi16, lo16, rdata16;
    logic        busy16;

    int n_vec  = 0;
    int n_miss = 0;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
    );

    mdu_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .hi(hi16), .lo(lo16), .rdata(rdata16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; holds start for exactly one rising edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE; a = '0; b = '0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic issue16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        start16 = 1'b1; op16 = o; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0; op16 = MDU_NONE; a16 = '0; b16 = '0;
    endtask

    task automatic wait_idle16(output int cyc);
        cyc = 0;
        while (busy16 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    // Reference result {hi, lo} computed in 64-bit arithmetic.
    function automatic logic [31:0] ref16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        longint sx, sy, ux, uy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            4'd1: begin p = sx * sy; return p[31:0]; end
            4'd2: begin p = ux * uy; return p[31:0]; end
            4'd3: begin
                if (y == 16'h0) return {x, 16'hFFFF};
                q = sx / sy; r = sx % sy;
                return {r[15:0], q[15:0]};
            end
            default: begin
                if (y == 16'h0) return {x, 16'hFFFF};
                q = ux / uy; r = ux % uy;
                return {r[15:0], q[15:0]};
            end
        endcase
    endfunction

    initial begin
        int cyc;
        logic [3:0]  o;
        logic [15:0] x, y;
        logic [31:0] exp16;

        reset = 1'b1; start = 1'b0; op = MDU_NONE; a = '0; b = '0;
        start16 = 1'b0; op16 = MDU_NONE; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_rdata", rdata, 0);

        // Reset in the middle of a multiply aborts it and clears HI/LO at once.
        issue(MDU_MTLO, 32'h55, 0);
        chk("mtlo_pre", lo, 32'h55);
        issue(MDU_MULT, 32'd3, 32'd4);
        chk("mult_busy", busy, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        op = MDU_MFLO;
        #1 chk("midrst_mflo", rdata, 0);
        op = MDU_NONE;
        @(negedge clk);

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(cyc);
        chk("multu_cycles", cyc, 5);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        issue(MDU_MULT, -32'sd3, 32'd7);
        wait_idle(cyc);
        chk("mult_cycles", cyc, 5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        op = MDU_MFHI;
        #1 chk("mfhi_rdata", rdata, 32'hFFFF_FFFF);
        op = MDU_MFLO;
        #1 chk("mflo_rdata", rdata, 32'hFFFF_FFEB);
        op = MDU_NONE;
        @(negedge clk);

        issue(MDU_DIV, -32'sd7, 32'd2);
        wait_idle(cyc);
        chk("div_cycles", cyc, 10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(MDU_DIVU, 32'd7, 32'd0);
        wait_idle(cyc);
        chk("divz_cycles", cyc, 10);
        chk("divz_hi", hi, 32'd7);
        chk("divz_lo", lo, 32'hFFFF_FFFF);

        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(MDU_MTLO, 32'h1234, 0);
        wait_idle(cyc);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);

        // mthi lands on the cycle busy falls; the following mult must not disturb HI early.
        issue(MDU_MTHI, 32'hA5, 0);
        chk("mthi_hi", hi, 32'hA5);
        issue(MDU_MULT, 32'd2, 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("b2b_hold_hi", hi, 32'hA5);
            @(negedge clk);
        end
        chk("b2b_hold_last", hi, 32'hA5);
        wait_idle(cyc);
        chk("b2b_cycles", cyc, 1);
        chk("b2b_hi", hi, 32'h0);
        chk("b2b_lo", lo, 32'h6);

        for (int i = 0; i < 12; i++) begin
            o = 4'(1 + (i % 4));
            x = 16'($urandom);
            y = 16'($urandom);
            if (i == 3)  y = 16'h0;
            if (i == 6)  begin x = 16'h8000; y = 16'hFFFF; end
            if (i == 10) y = 16'h0;
            exp16 = ref16(o, x, y);
            issue16(o, x, y);
            wait_idle16(cyc);
            chk("w16_cycles", cyc, (o <= 4'd2) ? 1 : 3);
            chk("w16_hi", hi16, exp16[31:16]);
            chk("w16_lo", lo16, exp16[15:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
